instr_sequencer: RTL and testbench



---
 rtl/instr_sequencer_if.sv | 32 +++
 rtl/instr_sequencer.sv | 150 +++++++++++++++
 tb/tb_instr_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// Bus bundle between the instruction sequencer and its ROM / regfile / board
// side. The master modport is the sequencer; the slave modport is the
// datapath side that supplies ROM data and regfile read data.
interface instr_sequencer_if #(
    parameter int PC_W = 3
);
    logic            run;
    logic [7:0]      instruction;
    logic [PC_W-1:0] address;
    logic [1:0]      rf_addr_a;
    logic [1:0]      rf_addr_b;
    logic [7:0]      rf_data_a;
    logic [7:0]      rf_data_b;
    logic            rf_we;
    logic [1:0]      rf_waddr;
    logic [7:0]      rf_wdata;
    logic [7:0]      result;
    logic            busy;
    logic [7:0]      instr_count;

    modport master (
        input  run, instruction, rf_data_a, rf_data_b,
        output address, rf_addr_a, rf_addr_b, rf_we, rf_waddr, rf_wdata,
               result, busy, instr_count
    );

    modport slave (
        output run, instruction, rf_data_a, rf_data_b,
        input  address, rf_addr_a, rf_addr_b, rf_we, rf_waddr, rf_wdata,
               result, busy, instr_count
    );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/execute controller for the 8-bit, 4-register datapath.
// Instruction: [7:6] opcode, [5:4] rd, [3:2] rb, [1:0] ra.
// Opcodes: 00 OUT, 01 ADD, 10 JMP, 11 LDI.
// Optional build macro SINGLE_STEP_EN: replaces the prescaler with a
// rising-edge detector on the 'step' input.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_WAIT  | idle, issue on tick && run
// S_FETCH | latch ROM data into ir
// S_EXEC  | regfile read ports driven, write data computed into a reg
// S_WB    | regfile write / result update, pc and instr_count advance
module instr_sequencer #(
    parameter int TICK_DIV = 10000000,
    parameter int PC_W     = 3
) (
    input logic clk,
    input logic rst_n,
`ifdef SINGLE_STEP_EN
    input logic step,
`endif
    instr_sequencer_if.master bus
);

    typedef enum logic [1:0] {S_WAIT, S_FETCH, S_EXEC, S_WB} state_t;

    localparam logic [1:0] OP_OUT = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_JMP = 2'b10;
    localparam logic [1:0] OP_LDI = 2'b11;

    state_t          state, state_nxt;
    logic [7:0]      ir;
    logic [7:0]      wdata_q;
    logic [7:0]      result_q;
    logic [7:0]      count_q;
    logic [PC_W-1:0] pc;
    logic            tick;
    logic            rf_we;
    logic [1:0]      rf_waddr;
    logic [1:0]      rf_addr_a;
    logic [1:0]      rf_addr_b;

`ifdef SINGLE_STEP_EN
    logic step_q;

    // Registered copy of step for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) step_q <= 1'b0;
        else        step_q <= step;
    end

    assign tick = step & ~step_q;
`else
    localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] presc;

    // Free-running prescaler; keeps counting while an instruction executes
    // so issue cadence stays fixed at TICK_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + 1'b1;
    end

    assign tick = (presc == CNT_LAST);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_WAIT;
        else        state <= state_nxt;
    end

    // Next-state and decoded regfile controls.
    always_comb begin
        state_nxt = state;
        rf_we     = 1'b0;
        rf_waddr  = 2'b00;
        rf_addr_a = 2'b00;
        rf_addr_b = 2'b00;
        case (state)
            S_WAIT: begin
                if (tick && bus.run) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                rf_addr_a = ir[1:0];
                rf_addr_b = ir[3:2];
                state_nxt = S_WB;
            end
            S_WB: begin
                rf_addr_a = ir[1:0];
                rf_addr_b = ir[3:2];
                if (ir[7:6] == OP_ADD || ir[7:6] == OP_LDI) begin
                    rf_we    = 1'b1;
                    rf_waddr = ir[5:4];
                end
                state_nxt = S_WAIT;
            end
            default: state_nxt = S_WAIT;
        endcase
    end

    // Datapath registers: ir capture, write-data compute, WB side effects.
    // OUT also routes R[ra] through wdata_q so result loads from a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir       <= '0;
            wdata_q  <= '0;
            result_q <= '0;
            count_q  <= '0;
            pc       <= '0;
        end else begin
            case (state)
                S_FETCH: ir <= bus.instruction;
                S_EXEC: begin
                    case (ir[7:6])
                        OP_ADD:  wdata_q <= bus.rf_data_a + bus.rf_data_b;
                        OP_LDI:  wdata_q <= {4'b0000, ir[3:0]};
                        OP_OUT:  wdata_q <= bus.rf_data_a;
                        default: wdata_q <= wdata_q;
                    endcase
                end
                S_WB: begin
                    if (ir[7:6] == OP_OUT) result_q <= wdata_q;
                    if (ir[7:6] == OP_JMP) pc <= ir[PC_W-1:0];
                    else                   pc <= pc + PC_W'(1);
                    count_q <= count_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.address     = pc;
    assign bus.rf_addr_a   = rf_addr_a;
    assign bus.rf_addr_b   = rf_addr_b;
    assign bus.rf_we       = rf_we;
    assign bus.rf_waddr    = rf_waddr;
    assign bus.rf_wdata    = wdata_q;
    assign bus.result      = result_q;
    assign bus.busy        = (state != S_WAIT);
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with TICK_DIV=4 and a small program in
// a bench-side ROM. Regfile read data is driven per instruction from the
// vector table.
module tb_instr_sequencer;

    localparam int TICK = 4;
    localparam int PCW  = 3;

    typedef struct {
        logic [7:0] instr;
        logic [2:0] pc;
        logic [2:0] next_pc;
        logic [7:0] da;
        logic [7:0] db;
        logic       we;
        logic [1:0] waddr;
        logic [7:0] wdata;
        logic [1:0] aa;
        logic [1:0] ab;
        logic [7:0] res;
    } vec_t;

    logic clk;
    logic rst_n;
    logic [7:0] rom [8];
    int n_checks;
    int n_errors;
    int cyc;
    int last_fetch;
    int exp_count;
    vec_t vecs [6];

    instr_sequencer_if #(.PC_W(PCW)) bus ();

    instr_sequencer #(.TICK_DIV(TICK), .PC_W(PCW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.instruction = rom[bus.address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(input logic [7:0] instr, input logic [2:0] pc,
                                input logic [2:0] next_pc, input logic [7:0] da,
                                input logic [7:0] db, input logic we,
                                input logic [1:0] waddr, input logic [7:0] wdata,
                                input logic [1:0] aa, input logic [1:0] ab,
                                input logic [7:0] res);
        vec_t v;
        v.instr = instr; v.pc = pc; v.next_pc = next_pc; v.da = da; v.db = db;
        v.we = we; v.waddr = waddr; v.wdata = wdata; v.aa = aa; v.ab = ab;
        v.res = res;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: no issue within bound (t=%0t)", name, $time);
    endtask

    task automatic wait_busy(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Runs one instruction from the next issue through the WAIT cycle after WB.
    task automatic exec_vec(input vec_t v, input bit chk_gap);
        bit ok;
        bus.rf_data_a = v.da;
        bus.rf_data_b = v.db;
        wait_busy(3 * TICK + 4, ok);
        if (!ok) begin
            fail_timeout("issue");
            return;
        end
        // FETCH
        check("fetch_addr", 32'(bus.address), 32'(v.pc));
        check("fetch_we", 32'(bus.rf_we), 0);
        check("fetch_ra", 32'(bus.rf_addr_a), 0);
        if (chk_gap) check("issue_gap", cyc - last_fetch, TICK);
        last_fetch = cyc;
        @(negedge clk);
        // EXEC
        check("exec_ra", 32'(bus.rf_addr_a), 32'(v.aa));
        check("exec_rb", 32'(bus.rf_addr_b), 32'(v.ab));
        check("exec_we", 32'(bus.rf_we), 0);
        check("exec_addr", 32'(bus.address), 32'(v.pc));
        @(negedge clk);
        // WB
        check("wb_we", 32'(bus.rf_we), 32'(v.we));
        check("wb_ra", 32'(bus.rf_addr_a), 32'(v.aa));
        check("wb_busy", 32'(bus.busy), 1);
        if (v.we) begin
            check("wb_waddr", 32'(bus.rf_waddr), 32'(v.waddr));
            check("wb_wdata", 32'(bus.rf_wdata), 32'(v.wdata));
        end
        @(negedge clk);
        // WAIT
        exp_count++;
        check("post_busy", 32'(bus.busy), 0);
        check("post_addr", 32'(bus.address), 32'(v.next_pc));
        check("post_result", 32'(bus.result), 32'(v.res));
        check("post_count", 32'(bus.instr_count), 32'(exp_count[7:0]));
        check("post_we", 32'(bus.rf_we), 0);
    endtask

    initial begin
        bit ok;
        bit saw;
        n_checks   = 0;
        n_errors   = 0;
        last_fetch = 0;
        exp_count  = 0;
        rst_n      = 1'b0;
        bus.run       = 1'b0;
        bus.rf_data_a = 8'h00;
        bus.rf_data_b = 8'h00;

        //        instr  pc  nxt da     db     we waddr wdata  aa ab res
        vecs[0] = mk(8'hD5, 0, 1, 8'h00, 8'h00, 1, 2'd1, 8'h05, 1, 1, 8'h00);
        vecs[1] = mk(8'h65, 1, 2, 8'hF0, 8'h20, 1, 2'd2, 8'h10, 1, 1, 8'h00);
        vecs[2] = mk(8'h01, 2, 3, 8'h5A, 8'h33, 0, 2'd0, 8'h00, 1, 0, 8'h5A);
        vecs[3] = mk(8'h86, 3, 6, 8'h11, 8'h22, 0, 2'd0, 8'h00, 2, 1, 8'h5A);
        vecs[4] = mk(8'hFE, 6, 7, 8'h00, 8'h00, 1, 2'd3, 8'h0E, 2, 3, 8'h5A);
        vecs[5] = mk(8'h4B, 7, 0, 8'h80, 8'h80, 1, 2'd0, 8'h00, 3, 2, 8'h5A);

        for (int i = 0; i < 8; i++) rom[i] = 8'h00;
        for (int i = 0; i < 6; i++) rom[vecs[i].pc] = vecs[i].instr;

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_addr", 32'(bus.address), 0);
        check("rst_result", 32'(bus.result), 0);
        check("rst_we", 32'(bus.rf_we), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_count", 32'(bus.instr_count), 0);
        bus.run = 1'b1;

        // Program walk: LDI, ADD wrap, OUT, JMP, LDI, ADD at pc 7 wrapping to 0
        for (int i = 0; i < 6; i++) exec_vec(vecs[i], i != 0);

        // JMP 0x83 from address 0 lands on 3
        rom[0] = 8'h83;
        exec_vec(mk(8'h83, 0, 3, 8'h00, 8'h00, 0, 2'd0, 8'h00, 3, 0, 8'h5A), 1);

        // JMP to own address keeps looping
        rom[3] = 8'h83;
        exec_vec(mk(8'h83, 3, 3, 8'h00, 8'h00, 0, 2'd0, 8'h00, 3, 0, 8'h5A), 1);
        rom[3] = 8'h86;

        // Drop run during FETCH: instruction finishes, then stall
        wait_busy(3 * TICK + 4, ok);
        if (!ok) fail_timeout("issue_before_stall");
        bus.run = 1'b0;
        repeat (3) @(negedge clk);
        exp_count++;
        check("stall_done_addr", 32'(bus.address), 6);
        check("stall_done_count", 32'(bus.instr_count), 32'(exp_count[7:0]));
        saw = 1'b0;
        repeat (3 * TICK) begin
            @(negedge clk);
            if (bus.busy) saw = 1'b1;
        end
        check("stall_busy", 32'(saw), 0);
        check("stall_addr", 32'(bus.address), 6);

        // Raise run: issue on next tick, then reset in the middle of EXEC
        bus.run = 1'b1;
        wait_busy(TICK + 1, ok);
        if (!ok) fail_timeout("resume");
        check("resume_addr", 32'(bus.address), 6);
        @(negedge clk);
        check("mid_exec_ra", 32'(bus.rf_addr_a), 2);
        rst_n = 1'b0;
        #1;
        check("arst_addr", 32'(bus.address), 0);
        check("arst_busy", 32'(bus.busy), 0);
        check("arst_we", 32'(bus.rf_we), 0);
        check("arst_ra", 32'(bus.rf_addr_a), 0);
        check("arst_result", 32'(bus.result), 0);
        check("arst_count", 32'(bus.instr_count), 0);
        check("arst_wdata", 32'(bus.rf_wdata), 0);
        bus.run = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.rf_we || bus.busy) saw = 1'b1;
        end
        check("post_rst_no_we", 32'(saw), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
